// File: rtl/moving_average_filter.sv
// ---------------------------------------------------------------------------
// moving_average_filter
//
// Smooths an unsigned sample stream with one of two runtime-selectable
// averagers:
//   boxcar (mode 0) : true moving average over N = 2^LOG2_N samples, kept in
//                     a circular delay buffer.
//   leaky  (mode 1) : exponential average, sum += x - (sum >> LOG2_N),
//                     time constant N samples.
// The mode is captured only while i_rst or i_clear is high, so a mid-stream
// change of i_mode has no effect until the next restart.
//
// Handshake: i_data_valid is a pure strobe with no backpressure; every cycle
// it is high (and neither i_rst nor i_clear is high) exactly one sample is
// accepted, and exactly one o_data_valid pulse follows on the next edge with
// o_data/o_sum updated alongside it. Outputs hold between pulses.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_data        unsigned input sample (DATA_W)
//   i_data_valid  sample strobe
//   i_mode        0 = boxcar, 1 = leaky (captured on reset/clear only)
//   i_clear       synchronous restart of sum, fill count and pointer
//   o_data        averaged sample, sum >> LOG2_N (DATA_W)
//   o_data_valid  one-cycle strobe per accepted sample
//   o_primed      high once N samples accepted since reset/clear
//   o_sum         registered accumulator (SUM_W), for level metering
//
// SUM_W is derived from DATA_W and LOG2_N and must be left at its default.
// ---------------------------------------------------------------------------
module moving_average_filter #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 6,
    parameter int SUM_W  = DATA_W + LOG2_N
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    input  logic              i_mode,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_primed,
    output logic [SUM_W-1:0]  o_sum
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(N);

    // Delay line for the boxcar; deliberately not reset; slots that have not
    // been written since the last restart are masked by the fill count.
    logic [DATA_W-1:0] r_buf [N];

    logic [LOG2_N-1:0] r_wp;
    logic [CNT_W-1:0]  r_fill;
    logic              r_mode;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_primed;

    logic              w_accept;
    logic              w_restart;
    logic              w_full;
    logic [DATA_W-1:0] w_old;
    logic [SUM_W-1:0]  w_sum_box;
    logic [SUM_W-1:0]  w_sum_leak;
    logic [SUM_W-1:0]  w_sum_next;
    logic [CNT_W-1:0]  w_fill_next;

    assign w_restart = i_rst | i_clear;
    assign w_accept  = i_data_valid & ~w_restart;
    assign w_full    = (r_fill == FILL_FULL);

    // Read-before-write: the sample leaving the window is read from the slot
    // that this cycle's sample is about to overwrite.
    assign w_old = w_full ? r_buf[r_wp] : '0;

    // Both updates are done modulo 2^SUM_W. The boxcar's sum + i_data can
    // momentarily exceed SUM_W bits when the window is full, but the final
    // result always fits, so modular wrap of the intermediate is exact.
    always_comb begin
        w_sum_box   = r_sum + SUM_W'(i_data) - SUM_W'(w_old);
        w_sum_leak  = r_sum - (r_sum >> LOG2_N) + SUM_W'(i_data);
        w_sum_next  = r_mode ? w_sum_leak : w_sum_box;
        w_fill_next = w_full ? r_fill : r_fill + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && !r_mode) begin
            r_buf[r_wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_restart) begin
            r_mode   <= i_mode;
            r_wp     <= '0;
            r_fill   <= '0;
            r_sum    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_valid <= i_data_valid;
            if (i_data_valid) begin
                r_sum    <= w_sum_next;
                r_data   <= w_sum_next[SUM_W-1:LOG2_N];
                r_fill   <= w_fill_next;
                r_primed <= (w_fill_next == FILL_FULL);
                // Pointer is only meaningful for the boxcar; wraps N-1 -> 0.
                if (!r_mode) begin
                    r_wp <= r_wp + 1'b1;
                end
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = r_valid;
    assign o_primed     = r_primed;
    assign o_sum        = r_sum;

endmodule

// File: tb/tb_moving_average_filter.sv
// ---------------------------------------------------------------------------
// tb_moving_average_filter
//
// Two instances: u_a with LOG2_N=2 (N=4) and u_b with the default LOG2_N=6
// (N=64). Stimulus tasks push the expected (primed, sum, data) triple for
// every accepted sample into a per-instance queue; an independent monitor
// pops and compares whenever o_data_valid is seen. Directed vectors carry
// hand-computed values; the long random-gap run uses a small reference model
// (boxcar recomputed from a sample history, leaky updated incrementally).
// ---------------------------------------------------------------------------
module tb_moving_average_filter;

    localparam int DW = 12;
    localparam int EW = 1 + 18 + 12;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          rst [2];
    logic          clr [2];
    logic          dv  [2];
    logic          md  [2];
    logic [DW-1:0] din [2];
    logic [DW-1:0] od  [2];
    logic          ov  [2];
    logic          op  [2];
    logic [13:0]   sum_a;
    logic [17:0]   sum_b;
    logic [17:0]   os  [2];

    assign os[0] = {4'b0, sum_a};
    assign os[1] = sum_b;

    moving_average_filter #(.DATA_W(12), .LOG2_N(2)) u_a (
        .i_clk        (clk),
        .i_rst        (rst[0]),
        .i_data       (din[0]),
        .i_data_valid (dv[0]),
        .i_mode       (md[0]),
        .i_clear      (clr[0]),
        .o_data       (od[0]),
        .o_data_valid (ov[0]),
        .o_primed     (op[0]),
        .o_sum        (sum_a)
    );

    moving_average_filter #(.DATA_W(12), .LOG2_N(6)) u_b (
        .i_clk        (clk),
        .i_rst        (rst[1]),
        .i_data       (din[1]),
        .i_data_valid (dv[1]),
        .i_mode       (md[1]),
        .i_clear      (clr[1]),
        .o_data       (od[1]),
        .o_data_valid (ov[1]),
        .o_primed     (op[1]),
        .o_sum        (sum_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_acc [2];
    int n_ov  [2];
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int d, input int s, input bit p);
        return {p, 18'(s), 12'(d)};
    endfunction

    function automatic void push_exp(input int i, input logic [EW-1:0] e);
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] qpop(input int i);
        return (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    // ---------------- reference model ----------------
    int m_lg   [2] = '{2, 6};
    int m_mode [2];
    int m_cnt  [2];
    int m_leak [2];
    int m_hist [2][1024];

    function automatic logic [EW-1:0] model_step(input int i, input int x);
        int n;
        int s;
        int k;
        n = 1 << m_lg[i];
        m_hist[i][m_cnt[i] % 1024] = x;
        m_cnt[i]++;
        if (m_mode[i] != 0) begin
            m_leak[i] = m_leak[i] - (m_leak[i] >> m_lg[i]) + x;
            s = m_leak[i];
        end else begin
            k = (m_cnt[i] < n) ? m_cnt[i] : n;
            s = 0;
            for (int j = 0; j < k; j++) s += m_hist[i][(m_cnt[i] - 1 - j) % 1024];
        end
        return pack(s >> m_lg[i], s, m_cnt[i] >= n);
    endfunction

    // ---------------- driver tasks ----------------
    // One call = one clock cycle of stimulus on instance i.
    task automatic drive(input int i, input bit r, input bit c, input bit v, input bit m,
                         input int x, input bit hand, input int hd, input int hs, input bit hp);
        logic [EW-1:0] e;
        @(negedge clk);
        rst[i] = r;
        clr[i] = c;
        dv[i]  = v;
        md[i]  = m;
        din[i] = DW'(x);
        if (r || c) begin
            m_mode[i] = int'(m);
            m_cnt[i]  = 0;
            m_leak[i] = 0;
        end else if (v) begin
            e = model_step(i, x);
            if (hand) e = pack(hd, hs, hp);
            push_exp(i, e);
            n_acc[i]++;
        end
    endtask

    task automatic do_reset(input int i, input bit m);
        drive(i, 1'b1, 1'b0, 1'b0, m, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int i);
        drive(i, 1'b0, 1'b0, 1'b0, 1'(($urandom_range(0, 1))), 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic send(input int i, input int x);
        drive(i, 1'b0, 1'b0, 1'b1, 1'(($urandom_range(0, 1))), x, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic send_h(input int i, input int x, input int hd, input int hs, input bit hp);
        drive(i, 1'b0, 1'b0, 1'b1, 1'(($urandom_range(0, 1))), x, 1'b1, hd, hs, hp);
    endtask

    // ---------------- monitor ----------------
    logic [EW-1:0] e_mon;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ov[i] === 1'b1) begin
                n_ov[i]++;
                if (qsize(i) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid[%0d]: got o_data_valid=1, required no output", i);
                end else begin
                    e_mon = qpop(i);
                    check($sformatf("o_data[%0d]", i), 32'(od[i]), 32'(e_mon[11:0]));
                    check($sformatf("o_sum[%0d]", i), 32'(os[i]), 32'(e_mon[29:12]));
                    check($sformatf("o_primed[%0d]", i), 32'(op[i]), 32'(e_mon[30]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int s;
    int r;
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; clr[i] = 1'b0; dv[i] = 1'b0; md[i] = 1'b0; din[i] = '0;
            m_mode[i] = 0; m_cnt[i] = 0; m_leak[i] = 0; n_acc[i] = 0; n_ov[i] = 0;
        end
        repeat (3) @(negedge clk);
        idle(0);
        idle(1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_o_data[%0d]", i), 32'(od[i]), 0);
            check($sformatf("reset_o_sum[%0d]", i), 32'(os[i]), 0);
            check($sformatf("reset_o_valid[%0d]", i), 32'(ov[i]), 0);
            check($sformatf("reset_o_primed[%0d]", i), 32'(op[i]), 0);
        end

        // Boxcar N=4: 4,8,12,16,20 -> 1,3,6,10,14, primed on the 4th.
        do_reset(0, 1'b0);
        send_h(0, 4, 1, 4, 1'b0);
        send_h(0, 8, 3, 12, 1'b0);
        send_h(0, 12, 6, 24, 1'b0);
        send_h(0, 16, 10, 40, 1'b1);
        send_h(0, 20, 14, 56, 1'b1);
        repeat (3) idle(0);
        check("hold_o_data", 32'(od[0]), 14);
        check("hold_o_sum", 32'(os[0]), 56);
        check("hold_o_valid", 32'(ov[0]), 0);
        check("hold_o_primed", 32'(op[0]), 1);

        // Leaky N=4, constant 16: sums 16,28,37,44 ... settles at 64.
        do_reset(0, 1'b1);
        send_h(0, 16, 4, 16, 1'b0);
        send_h(0, 16, 7, 28, 1'b0);
        send_h(0, 16, 9, 37, 1'b0);
        send_h(0, 16, 11, 44, 1'b1);
        for (int k = 5; k < 20; k++) send(0, 16);
        send_h(0, 16, 16, 64, 1'b1);

        // Clear with a simultaneous sample and i_mode=1: sample dropped,
        // state zeroed, mode becomes leaky.
        do_reset(0, 1'b0);
        send_h(0, 4, 1, 4, 1'b0);
        send_h(0, 8, 3, 12, 1'b0);
        send_h(0, 12, 6, 24, 1'b0);
        drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 100, 1'b0, 0, 0, 1'b0);
        send_h(0, 8, 2, 8, 1'b0);
        check("clear_o_valid", 32'(ov[0]), 0);
        check("clear_o_sum", 32'(os[0]), 0);
        check("clear_o_primed", 32'(op[0]), 0);
        check("clear_o_data", 32'(od[0]), 0);
        send_h(0, 8, 3, 14, 1'b0);
        repeat (2) idle(0);

        // Boxcar N=64: 64 x 100 then 100 x 0.
        do_reset(1, 1'b0);
        for (int k = 1; k <= 64; k++) send_h(1, 100, (100 * k) >> 6, 100 * k, k == 64);
        for (int j = 1; j <= 100; j++) begin
            s = (j < 64) ? 100 * (64 - j) : 0;
            send_h(1, 0, s >> 6, s, 1'b1);
        end

        // Boxcar N=64 at full scale, then one zero.
        do_reset(1, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            s = 4095 * ((k < 64) ? k : 64);
            send_h(1, 4095, s >> 6, s, k >= 64);
        end
        send_h(1, 0, 4031, 257985, 1'b1);
        repeat (2) idle(1);

        // Random valid gaps, random i_mode toggling, occasional clear/reset.
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                do_reset(i, 1'(m));
                for (int k = 0; k < 2500; k++) begin
                    r = $urandom_range(0, 199);
                    if (r == 0)
                        drive(i, 1'b0, 1'b1, 1'(($urandom_range(0, 1))), 1'(m), 7, 1'b0, 0, 0, 1'b0);
                    else if (r == 1)
                        drive(i, 1'b1, 1'b0, 1'(($urandom_range(0, 1))), 1'(m), 9, 1'b0, 0, 0, 1'b0);
                    else if (r < 100)
                        idle(i);
                    else if (r < 110)
                        send(i, (r < 105) ? 4095 : 0);
                    else
                        send(i, $urandom_range(0, 4095));
                end
                repeat (3) idle(i);
            end
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pending_expected[%0d]", i), 32'(qsize(i)), 0);
            check($sformatf("valid_count[%0d]", i), 32'(n_ov[i]), 32'(n_acc[i]));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
